// File: rtl/fsac_reg_bank_if.sv
// Decoded SPI-slave transaction bus shared between the SPI slave and the register bank.
// The master side is the SPI slave, which issues transactions; the slave side is the bank.
interface fsac_reg_bank_if;
   logic [7:0] spi_reg_addr;
   logic [7:0] spi_wr_data;
   logic       spi_rw;
   logic       spi_sel_end;
   logic [7:0] spi_rd_data;

   modport master (
      output spi_reg_addr,
      output spi_wr_data,
      output spi_rw,
      output spi_sel_end,
      input  spi_rd_data
   );

   modport slave (
      input  spi_reg_addr,
      input  spi_wr_data,
      input  spi_rw,
      input  spi_sel_end,
      output spi_rd_data
   );
endinterface

// File: rtl/fsac_reg_bank.sv
// Register bank behind the SPI slave: ID/scratch/filter shadow-and-apply,
// plus a gated edge counter that measures the frequency of freq_in.
module fsac_reg_bank #(
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter int         GATE_CYCLES = 25000000,
   parameter int         CNT_W       = 24
) (
   input  logic             sys_clk_25m,
   input  logic             sys_rstn,
   fsac_reg_bank_if.slave   spi,
   input  logic             freq_in,
   output logic [7:0]       filter_switch,
   output logic             freq_valid
);

   localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } MeasState;

   MeasState          r_state;
   MeasState          w_nextState;
   logic              r_selEndD;
   logic [7:0]        r_scratch;
   logic [7:0]        r_filtShadow;
   logic [7:0]        r_filterSwitch;
   logic              r_freqEn;
   logic              r_freqValid;
   logic [CNT_W-1:0]  r_freqCnt;
   logic [CNT_W-1:0]  r_edgeCnt;
   logic [GATE_W-1:0] r_gateCnt;
   logic [7:0]        r_rdData;
   logic              r_sync1;
   logic              r_sync2;
   logic              r_sync3;
   logic              w_txn;
   logic              w_wrStb;
   logic              w_ctrlWr;
   logic              w_clrValid;
   logic              w_rise;
   logic              w_capture;
   logic [CNT_W-1:0]  w_edgeNext;
   logic [7:0]        w_rdMux;

   // A level held high on spi_sel_end yields a single-cycle strobe.
   assign w_txn      = spi.spi_sel_end & ~r_selEndD;
   assign w_wrStb    = w_txn & spi.spi_rw;
   assign w_ctrlWr   = w_wrStb & (spi.spi_reg_addr == 8'h03);
   assign w_clrValid = w_ctrlWr & spi.spi_wr_data[2];
   assign w_rise     = r_sync2 & ~r_sync3;
   assign w_edgeNext = (&r_edgeCnt) ? r_edgeCnt : r_edgeCnt + CNT_W'(w_rise);

   assign spi.spi_rd_data = r_rdData;
   assign filter_switch   = r_filterSwitch;
   assign freq_valid      = r_freqValid;

   always_ff @(posedge sys_clk_25m) begin
      if (!sys_rstn) begin
         r_selEndD <= 1'b0;
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync3   <= 1'b0;
         r_rdData  <= 8'h00;
      end else begin
         r_selEndD <= spi.spi_sel_end;
         r_sync1   <= freq_in;
         r_sync2   <= r_sync1;
         r_sync3   <= r_sync2;
         r_rdData  <= w_rdMux;
      end
   end

   always_ff @(posedge sys_clk_25m) begin
      if (!sys_rstn) begin
         r_scratch      <= 8'h00;
         r_filtShadow   <= 8'h00;
         r_filterSwitch <= 8'h00;
         r_freqEn       <= 1'b0;
      end else if (w_wrStb) begin
         case (spi.spi_reg_addr)
            8'h01: r_scratch    <= spi.spi_wr_data;
            8'h02: r_filtShadow <= spi.spi_wr_data;
            8'h03: begin
               r_freqEn <= spi.spi_wr_data[1];
               if (spi.spi_wr_data[0]) r_filterSwitch <= r_filtShadow;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk_25m) begin
      if (!sys_rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      case (r_state)
         IDLE:  if (r_freqEn) w_nextState = COUNT;
         COUNT: begin
            if (!r_freqEn) begin
               w_nextState = IDLE;
            end else if (r_gateCnt == GATE_LAST) begin
               w_nextState = DONE;
               w_capture   = 1'b1;
            end
         end
         DONE:  w_nextState = r_freqEn ? COUNT : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Counters run only in COUNT; IDLE and the single DONE cycle hold them at zero.
   always_ff @(posedge sys_clk_25m) begin
      if (!sys_rstn) begin
         r_gateCnt <= '0;
         r_edgeCnt <= '0;
      end else if (r_state == COUNT) begin
         r_gateCnt <= r_gateCnt + 1'b1;
         r_edgeCnt <= w_edgeNext;
      end else begin
         r_gateCnt <= '0;
         r_edgeCnt <= '0;
      end
   end

   always_ff @(posedge sys_clk_25m) begin
      if (!sys_rstn) begin
         r_freqCnt   <= '0;
         r_freqValid <= 1'b0;
      end else begin
         if (w_capture) r_freqCnt <= w_edgeNext;
         if (w_capture) begin
            r_freqValid <= 1'b1;
         end else if (w_clrValid) begin
            r_freqValid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rdMux = 8'h00;
      case (spi.spi_reg_addr)
         8'h00: w_rdMux = ID_VALUE;
         8'h01: w_rdMux = r_scratch;
         8'h02: w_rdMux = r_filtShadow;
         8'h03: w_rdMux = {6'b0, r_freqEn, 1'b0};
         8'h04: w_rdMux = {6'b0, (r_state == COUNT), r_freqValid};
         8'h05: w_rdMux = r_freqCnt[7:0];
         8'h06: w_rdMux = r_freqCnt[15:8];
         8'h07: w_rdMux = r_freqCnt[23:16];
         default: w_rdMux = 8'h00;
      endcase
   end

endmodule

// File: doc/fsac_reg_bank.md
Name: fsac_reg_bank

Overview:
- Register bank and frequency-measurement stage directly downstream of the SPI slave.
- Consumes the slave's decoded transaction bus (address, write data, read/write flag, end-of-transaction marker) and returns read data to it.
- Owns the filter_switch output through a shadow-and-apply mechanism.
- Runs a gated edge counter that measures the frequency of an external input, readable over SPI.

Parameters:
- ID_VALUE, 8'hA5, constant returned by register 0x00.
- GATE_CYCLES, 25000000, gate window length in sys_clk_25m cycles (1 s at 25 MHz); minimum 2.
- CNT_W, 24, edge-counter width; fixed at 24 for the 3-byte register map.

Ports:
- sys_clk_25m  in  1  system clock, 25 MHz; all logic on its rising edge.
- sys_rstn  in  1  reset, synchronous, active-low.
- spi_reg_addr  in  8  register address from SPI slave; valid while spi_sel_end is high.
- spi_wr_data  in  8  write data from SPI slave; valid while spi_sel_end is high.
- spi_rw  in  1  1 = write, 0 = read; valid while spi_sel_end is high.
- spi_sel_end  in  1  transaction-complete level from SPI slave, synchronous to sys_clk_25m.
- spi_rd_data  out  8  registered read data for spi_reg_addr.
- freq_in  in  1  asynchronous signal under measurement.
- filter_switch  out  8  filter relay/switch control.
- freq_valid  out  1  measurement available (mirrors STATUS bit0).

Behaviour:
- Reset (sys_rstn=0 at a clock edge): all registers, counters and FSM return to reset values.
  - spi_rd_data = 8'h00, filter_switch = 8'h00, freq_valid = 0.
  - SCRATCH = 0, FILT_SHADOW = 0, CTRL = 0, FREQ_CNT = 0, FSM = IDLE.
  - Reset mid-gate aborts the gate with no capture.
- Transaction strobe:
  - txn = spi_sel_end & ~spi_sel_end_d, where spi_sel_end_d is spi_sel_end delayed by one register.
  - A write takes effect on the cycle after txn with spi_rw=1.
  - A level held high produces exactly one strobe.
- Read path:
  - spi_rd_data is registered every cycle from the current spi_reg_addr (1-cycle latency), independent of txn.
  - Unmapped addresses read 8'h00.
- Register map:
  - 0x00 ID, RO: reads ID_VALUE.
  - 0x01 SCRATCH, RW.
  - 0x02 FILT_SHADOW, RW. Does not affect filter_switch until applied.
  - 0x03 CTRL:
    - bit0 APPLY, write-1 pulse: filter_switch <= FILT_SHADOW on the cycle after the write strobe.
    - bit1 FREQ_EN, RW.
    - bit2 CLR_VALID, write-1 pulse.
    - Bits 0 and 2 always read 0.
    - Writing APPLY together with a FILT_SHADOW change is impossible (single address per txn). APPLY uses the FILT_SHADOW value held at strobe time.
  - 0x04 STATUS, RO: bit0 freq_valid, bit1 busy (FSM == COUNT), others 0.
  - 0x05/0x06/0x07 FREQ_CNT[7:0]/[15:8]/[23:16], RO. Snapshot register; only updated at capture, so a multi-byte read is coherent unless a capture occurs between byte reads.
  - Writes to RO or unmapped addresses are ignored.
- Input synchroniser:
  - freq_in passes through a 2-FF synchroniser plus one edge-detect register.
  - rise = s2 & ~s3.
- Measurement FSM:
  - IDLE: gate_cnt = 0, edge_cnt = 0. If FREQ_EN=1, go to COUNT.
  - COUNT: gate_cnt increments every cycle; edge_cnt increments on rise, saturating at 24'hFFFFFF.
    - If FREQ_EN=0, go to IDLE (abort, no capture, freq_valid unchanged).
    - When gate_cnt == GATE_CYCLES-1, go to DONE. FREQ_CNT <= edge_cnt + rise (saturated); freq_valid <= 1.
  - DONE: clear gate_cnt and edge_cnt. Go to COUNT if FREQ_EN=1, else IDLE. Exactly one dead cycle between gates; an edge in the DONE cycle is not counted.
- freq_valid:
  - Set by capture, cleared by CLR_VALID.
  - If capture and CLR_VALID occur in the same cycle, capture wins and freq_valid = 1.

Test Plan:
- Reset check: release reset, then read 0x00, 0x01, 0x03, 0x04 -> spi_rd_data A5, 00, 00, 00. filter_switch = 00, freq_valid = 0.
- Shadow/apply: write 0x02=3C -> filter_switch stays 00. Write 0x03=01 -> filter_switch = 3C one cycle after the strobe. Read 0x03 -> 00.
- Strobe uniqueness: hold spi_sel_end high for 10 cycles with write 0x01=55 -> exactly one write. Read 0x01 -> 55. Read 0xFE -> 00. Write 0x00=FF -> ID still reads A5.
- Frequency capture: GATE_CYCLES=100, freq_in period 10 clocks, write 0x03=02.
  - After 101 cycles, freq_valid = 1 and FREQ_CNT = 10 (±1 for phase).
  - Continuous mode: the next capture follows 101 cycles later.
  - Reads 0x05/06/07 -> 0A/00/00.
- Abort and clear:
  - Write 0x03=00 at gate_cnt=50 -> STATUS bit1 = 0, FREQ_CNT unchanged.
  - Write 0x03=04 -> freq_valid = 0.
  - Issue CLR_VALID on the capture cycle -> freq_valid stays 1.
- Reset mid-operation: assert sys_rstn=0 during COUNT with filter_switch=3C -> next edge gives filter_switch = 00, STATUS = 00, FREQ_CNT = 000000.
